// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: frame geometry, input format codes,
// the pixel packer state encoding and the RGB888 -> RGB565 reduction.
package fb_pkg;

  localparam int H_RES    = 320;
  localparam int V_RES    = 240;
  localparam int FB_DEPTH = H_RES * V_RES;

  localparam logic FMT_RGB565 = 1'b0;
  localparam logic FMT_RGB888 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } pk_state_t;

  // Truncating reduction, no rounding.
  function automatic logic [15:0] rgb888_to_565(input logic [7:0] r,
                                                input logic [7:0] g,
                                                input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

endpackage

// File: rtl/sd_pixel_packer.sv
// Packs the SD byte stream into RGB565 frame-buffer writes with sequential
// addresses, after discarding an optional header; flags the end of a frame.
module sd_pixel_packer #(
  parameter int H_RES        = fb_pkg::H_RES,
  parameter int V_RES        = fb_pkg::V_RES,
  parameter int HEADER_BYTES = 0,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fmt_rgb888,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic [15:0]       pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_we,
  output logic              busy,
  output logic              frame_done,
  output logic              dropped,
  output logic [1:0]        state_dbg
);
  import fb_pkg::*;

  // Handshake: in_valid qualifies in_data for exactly one cycle and there is
  // no backpressure; pix_we qualifies pix_data/pix_addr for one cycle.

  localparam int                DEPTH    = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       HDR_LAST = 16'((HEADER_BYTES > 0) ? HEADER_BYTES - 1 : 0);
  localparam pk_state_t         FIRST_ST = (HEADER_BYTES > 0) ? SKIP : PACK;

  pk_state_t         state, state_nxt;
  logic              fmt;
  logic [15:0]       hdr_cnt;
  logic [1:0]        byte_phase;
  logic [7:0]        b0, b1;
  logic [ADDR_W-1:0] pix_cnt;
  logic              pix_last_byte;
  logic [15:0]       pix_packed;

  always_comb begin
    pix_last_byte = (state == PACK) && in_valid &&
                    (byte_phase == ((fmt == FMT_RGB888) ? 2'd2 : 2'd1));
    pix_packed    = (fmt == FMT_RGB888) ? rgb888_to_565(b0, b1, in_data) : {b0, in_data};
    state_nxt     = state;
    if (start) begin
      // A start always wins, including over a pixel-completing byte.
      state_nxt = FIRST_ST;
    end else begin
      case (state)
        SKIP:    if (in_valid && hdr_cnt == HDR_LAST) state_nxt = PACK;
        PACK:    if (pix_last_byte && pix_cnt == LAST_PIX) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fmt        <= 1'b0;
      hdr_cnt    <= '0;
      byte_phase <= '0;
      b0         <= '0;
      b1         <= '0;
      pix_cnt    <= '0;
      pix_data   <= '0;
      pix_addr   <= '0;
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      dropped    <= in_valid && (state == IDLE || state == DONE);
      if (start) begin
        fmt        <= fmt_rgb888;
        hdr_cnt    <= '0;
        byte_phase <= '0;
        pix_cnt    <= '0;
      end else if (state == SKIP && in_valid) begin
        hdr_cnt <= hdr_cnt + 16'd1;
      end else if (state == PACK && in_valid) begin
        if (pix_last_byte) begin
          byte_phase <= '0;
          pix_we     <= 1'b1;
          pix_addr   <= pix_cnt;
          pix_data   <= pix_packed;
          frame_done <= (pix_cnt == LAST_PIX);
          // Hold at the last address so the counter never wraps.
          if (pix_cnt != LAST_PIX) pix_cnt <= pix_cnt + 1'b1;
        end else begin
          byte_phase <= byte_phase + 2'd1;
          if (byte_phase == 2'd0) b0 <= in_data;
          else                    b1 <= in_data;
        end
      end
    end
  end

  assign busy      = (state == SKIP) || (state == PACK);
  assign state_dbg = state;

endmodule
